// File: rtl/blink_multi.sv
// Board bring-up pattern generator: prescaled step clock drives one of four LED
// patterns and a free-running hex step count on seven-segment digits.
module blink_multi #(
  parameter int unsigned CLK_HZ  = 10_000_000,
  parameter int unsigned TICK_HZ = 4,
  parameter int unsigned N_LED   = 16,
  parameter int unsigned N_HEX   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [1:0]           speed,
  input  logic                 pause,
  output logic [N_LED-1:0]     led,
  output logic [8*N_HEX-1:0]   hex,
  output logic                 tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned CW  = 4 * N_HEX;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    M_BLINK  = 2'd0,
    M_CHASE  = 2'd1,
    M_BOUNCE = 2'd2,
    M_COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [1:0]       mode_q;
  mode_e            act_q, act_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [2:0]       spd_q, spd_d;
  dir_e             dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick_q, tick_d;

  logic             base_tick, step_en, mode_chg;
  logic [2:0]       spd_lim;
  logic [8*N_HEX-1:0] hex_c;

  function automatic logic [N_LED-1:0] init_pat(input mode_e m);
    case (m)
      M_CHASE, M_BOUNCE: init_pat = N_LED'(1);
      default:           init_pat = '0;
    endcase
  endfunction

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign spd_lim   = 3'((4'd1 << speed) - 4'd1);
  assign base_tick = (pre_q == PRE_MAX);
  assign mode_chg  = (mode_e'(mode_q) != act_q);
  // A pending mode reload swallows any coincident step.
  assign step_en   = base_tick && (spd_q == spd_lim) && !pause && !mode_chg;

  always_comb begin
    act_d  = act_q;
    pre_d  = pre_q;
    spd_d  = spd_q;
    dir_d  = dir_q;
    led_d  = led_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (mode_chg) begin
      act_d = mode_e'(mode_q);
      led_d = init_pat(mode_e'(mode_q));
      pre_d = '0;
      spd_d = '0;
      dir_d = DIR_UP;
    end else if (!pause) begin
      pre_d = base_tick ? '0 : pre_q + PW'(1);
      if (step_en)        spd_d = '0;
      else if (base_tick) spd_d = spd_q + 3'd1;
      if (step_en) begin
        tick_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        case (act_q)
          M_BLINK: led_d = ~led_q;
          M_CHASE: led_d = (led_q << 1) | (led_q >> (N_LED - 1));
          M_BOUNCE: begin
            if (N_LED == 1) begin
              led_d = N_LED'(1);
            end else if (dir_q == DIR_UP) begin
              if (led_q[N_LED-1]) begin
                led_d = led_q >> 1;
                dir_d = DIR_DOWN;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = DIR_UP;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          M_COUNT: led_d = led_q + N_LED'(1);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      act_q  <= M_BLINK;
      pre_q  <= '0;
      spd_q  <= '0;
      dir_q  <= DIR_UP;
      led_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode;
      act_q  <= act_d;
      pre_q  <= pre_d;
      spd_q  <= spd_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Digit 0 dp mirrors the step count LSB; other dps stay dark.
  always_comb begin
    hex_c = '1;
    for (int unsigned k = 0; k < N_HEX; k++) begin
      hex_c[8*k +: 8] = {(k == 0) ? ~cnt_q[0] : 1'b1, seg7(cnt_q[4*k +: 4])};
    end
  end

  assign led  = led_q;
  assign hex  = hex_c;
  assign tick = tick_q;

endmodule

// File: tb/tb_blink_multi.sv
// Directed bench for blink_multi with DIV=4, four LEDs and two hex digits.
module tb_blink_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  speed;
  logic        pause;
  logic [3:0]  led;
  logic [15:0] hex;
  logic        tick;

  int tests = 0;
  int fails = 0;

  blink_multi #(
    .CLK_HZ (16),
    .TICK_HZ(4),
    .N_LED  (4),
    .N_HEX  (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .speed(speed),
    .pause(pause),
    .led  (led),
    .hex  (hex),
    .tick (tick)
  );

  always #5 clk = ~clk;

  // Counts rising edges until tick is seen (sampled 1 time unit after each edge).
  task automatic wait_tick(input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
      if (tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; speed = 2'd0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (led !== 4'h0) begin fails++; $display("FAIL reset_led: got %h expected 0", led); end
    tests++; if (hex !== 16'hC0C0) begin fails++; $display("FAIL reset_hex: got %h expected C0C0", hex); end
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", tick); end
  endtask

  task automatic test_blink();
    int n; bit ok;
    @(negedge clk); rst = 1'b0;
    wait_tick(20, n, ok);
    tests++; if (!ok || n != 4) begin fails++; $display("FAIL blink_first_latency: got %0d edges (seen=%0d) expected 4", n, ok); end
    tests++; if (led !== 4'hF) begin fails++; $display("FAIL blink_led1: got %h expected F", led); end
    tests++; if (hex !== 16'hC079) begin fails++; $display("FAIL blink_hex1: got %h expected C079", hex); end
    @(posedge clk); #1;
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL blink_tick_width: got %b expected 0", tick); end
    wait_tick(20, n, ok);
    tests++; if (!ok || n != 3) begin fails++; $display("FAIL blink_period: got %0d edges (seen=%0d) expected 3", n, ok); end
    tests++; if (led !== 4'h0) begin fails++; $display("FAIL blink_led2: got %h expected 0", led); end
    tests++; if (hex !== 16'hC0A4) begin fails++; $display("FAIL blink_hex2: got %h expected C0A4", hex); end
  endtask

  task automatic test_chase();
    int n; bit ok;
    logic [3:0] exp_c [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    mode = 2'd1;
    @(posedge clk); @(posedge clk); #1;
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL chase_reload: got %b expected 0001", led); end
    for (int i = 0; i < 4; i++) begin
      wait_tick(20, n, ok);
      tests++; if (!ok || n != 4) begin fails++; $display("FAIL chase_period[%0d]: got %0d edges (seen=%0d) expected 4", i, n, ok); end
      tests++; if (led !== exp_c[i]) begin fails++; $display("FAIL chase_led[%0d]: got %b expected %b", i, led, exp_c[i]); end
    end
  endtask

  task automatic test_bounce();
    int n; bit ok;
    logic [3:0] exp_b [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    mode = 2'd2;
    @(posedge clk); @(posedge clk); #1;
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL bounce_reload: got %b expected 0001", led); end
    for (int i = 0; i < 7; i++) begin
      wait_tick(20, n, ok);
      tests++; if (!ok || led !== exp_b[i]) begin fails++; $display("FAIL bounce_led[%0d]: got %b (seen=%0d) expected %b", i, led, ok, exp_b[i]); end
    end
    tests++; if (hex !== 16'hC021) begin fails++; $display("FAIL bounce_hex: got %h expected C021", hex); end
  endtask

  task automatic test_count();
    int n; bit ok;
    logic [7:0] exp_cnt;
    logic [3:0] exp_l;
    mode = 2'd3; speed = 2'd2;
    @(posedge clk); @(posedge clk); #1;
    tests++; if (led !== 4'h0) begin fails++; $display("FAIL count_reload: got %h expected 0", led); end
    for (int i = 1; i <= 16; i++) begin
      exp_l = 4'(i);
      wait_tick(40, n, ok);
      tests++; if (!ok || n != 16) begin fails++; $display("FAIL count_period[%0d]: got %0d edges (seen=%0d) expected 16", i, n, ok); end
      tests++; if (led !== exp_l) begin fails++; $display("FAIL count_led[%0d]: got %h expected %h", i, led, exp_l); end
    end
    speed = 2'd0;
    exp_cnt = 8'd29;
    while (exp_cnt != 8'hFF) begin
      wait_tick(8, n, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL count_fast_timeout: no tick within 8 edges at count %h", exp_cnt);
        break;
      end
      exp_cnt++;
    end
    tests++; if (hex !== 16'h8E0E) begin fails++; $display("FAIL count_hex_ff: got %h expected 8E0E", hex); end
    wait_tick(8, n, ok);
    tests++; if (!ok || hex !== 16'hC0C0) begin fails++; $display("FAIL count_hex_wrap: got %h (seen=%0d) expected C0C0", hex, ok); end
  endtask

  task automatic test_pause();
    int n; bit ok;
    int tick_seen, changed;
    mode = 2'd1;
    @(posedge clk); @(posedge clk); #1;
    wait_tick(20, n, ok);
    tests++; if (!ok || led !== 4'b0010) begin fails++; $display("FAIL pause_pre_led: got %b (seen=%0d) expected 0010", led, ok); end
    @(posedge clk); @(posedge clk); #1;
    pause = 1'b1;
    tick_seen = 0; changed = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tick !== 1'b0) tick_seen++;
      if (led !== 4'b0010 || hex !== 16'hC079) changed++;
    end
    tests++; if (tick_seen != 0) begin fails++; $display("FAIL pause_tick: got %0d ticks expected 0", tick_seen); end
    tests++; if (changed != 0) begin fails++; $display("FAIL pause_hold: got %0d changed samples expected 0", changed); end
    pause = 1'b0;
    wait_tick(10, n, ok);
    tests++; if (!ok || n != 2) begin fails++; $display("FAIL pause_resume_latency: got %0d edges (seen=%0d) expected 2", n, ok); end
    tests++; if (led !== 4'b0100) begin fails++; $display("FAIL pause_resume_led: got %b expected 0100", led); end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    mode = 2'd2;
    @(posedge clk); @(posedge clk); #1;
    wait_tick(20, n, ok);
    wait_tick(20, n, ok);
    tests++; if (!ok || led !== 4'b0100) begin fails++; $display("FAIL rstmid_pre_led: got %b (seen=%0d) expected 0100", led, ok); end
    #1; rst = 1'b1; mode = 2'd0;
    #1;
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL rstmid_tick: got %b expected 0", tick); end
    tests++; if (led !== 4'h0) begin fails++; $display("FAIL rstmid_led: got %h expected 0", led); end
    tests++; if (hex !== 16'hC0C0) begin fails++; $display("FAIL rstmid_hex: got %h expected C0C0", hex); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wait_tick(20, n, ok);
    tests++; if (!ok || n != 4) begin fails++; $display("FAIL rstmid_latency: got %0d edges (seen=%0d) expected 4", n, ok); end
    tests++; if (led !== 4'hF || hex !== 16'hC079) begin fails++; $display("FAIL rstmid_restart: got led %h hex %h expected F C079", led, hex); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_chase();
    test_bounce();
    test_count();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
